inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction-side responder for the core: takes the core's next_pc fetch request and
//  returns the 32-bit instruction word that the core's inst input consumes.
//  Issues 64-bit aligned reads on a valid/ready memory port.
//  Keeps a one-entry line buffer, so both halves of a double-word cost one memory read.
//  Sits between the core top and the instruction memory / bus bridge.
// PARAMETERS
//  ADDR_WIDTH  64  PC / memory address width
//  INST_WIDTH  32  instruction width (fixed RV encoding)
//  DATA_WIDTH  64  memory read data width; line = 8 bytes
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst            in   1           synchronous reset, active-high
//  fetch_valid    in   1           core presents fetch_pc
//  fetch_ready    out  1           IFU can accept a fetch this cycle
//  fetch_pc       in   ADDR_WIDTH  address of instruction to fetch
//  flush          in   1           redirect/fence.i: cancel in-flight fetch, invalidate buffer
//  inst_valid     out  1           one-cycle pulse, inst/inst_pc valid
//  inst           out  INST_WIDTH  fetched instruction
//  inst_pc        out  ADDR_WIDTH  pc that inst belongs to
//  misalign       out  1           misaligned-fetch flag, qualified by inst_valid
//  mem_req_valid  out  1           read request valid
//  mem_req_ready  in   1           memory accepts request
//  mem_addr       out  ADDR_WIDTH  {pc[ADDR_WIDTH-1:3],3'b0}
//  mem_rsp_valid  in   1           read data valid; exactly one response per accepted request
//  mem_rdata      in   DATA_WIDTH  read data
// BEHAVIOUR
//  Reset: state=IDLE; buffer invalid.
//  Reset values: fetch_ready=0, inst_valid=0, inst=0, inst_pc=0, misalign=0,
//    mem_req_valid=0, mem_addr=0. fetch_ready rises the cycle after rst drops.
//  FSM states: IDLE, REQ, WAIT, DROP.
//  fetch_ready = (state==IDLE) & ~flush & ~inst_valid. Accept = fetch_valid & fetch_ready.
//  IDLE, accept at T:
//    - Buffer hit (valid & tag==pc[ADDR_WIDTH-1:3]): inst_valid=1 at T+1, stay IDLE.
//    - Miss: latch pc, mem_req_valid=1 from T+1, go REQ.
//  REQ: hold mem_req_valid and mem_addr stable until mem_req_ready; then go WAIT.
//  WAIT: on mem_rsp_valid at cycle R:
//    - load buffer (tag, data);
//    - at R+1: inst_valid=1, inst=pc[2] ? rdata[63:32] : rdata[31:0];
//    - go IDLE.
//  Hit latency = 1 cycle; miss latency = 1 + req wait + mem latency + 1.
//  inst/inst_pc/misalign hold their value between pulses.
//  flush:
//    - Invalidates the buffer in every state.
//    - IDLE: no-op; flush has priority over a same-cycle fetch_valid (not accepted).
//    - REQ: request still held until handshake, then go DROP (never retract valid).
//    - WAIT: go DROP. A response in the same cycle as flush is discarded -> IDLE.
//    - DROP: on mem_rsp_valid -> IDLE; data is not buffered and inst_valid stays 0.
//    - A flush in the cycle inst_valid=1 does not kill that pulse.
//  Reset mid-operation: immediate return to IDLE. The memory side is reset by the same rst.
//  No outstanding-request depth > 1. mem_rsp_valid outside WAIT/DROP is ignored.
// CONFIGURATION
//  IFU_MISALIGN_CHECK_EN defined:
//    - Accepted fetch with pc[1:0]!=0 performs no memory access and no buffer lookup.
//    - Next cycle: inst_valid=1, inst=0, misalign=1.
//  IFU_MISALIGN_CHECK_EN undefined:
//    - pc[1:0] ignored (treated as 0); misalign tied 0.
// TESTING
//  1. Reset then fetch pc=0x80000000, mem returns 0x00000013_00100093 after 2 cycles
//     -> one mem req addr 0x80000000, inst=0x00100093.
//  2. Then fetch pc=0x80000004 -> no mem_req_valid, inst_valid next cycle, inst=0x00000013.
//  3. Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_addr stable all 5 cycles.
//     Handshake occurs on the 6th cycle.
//  4. Miss at 0x80000010, flush in WAIT, response 0xDEADBEEF_CAFEF00D arrives
//     -> no inst_valid; refetch 0x80000010 issues a new mem req (buffer invalid).
//  5. flush and fetch_valid in the same cycle in IDLE -> fetch not accepted, no mem req.
//     Reset asserted in WAIT -> IDLE, outputs at reset values next cycle.
//  6. With IFU_MISALIGN_CHECK_EN, fetch pc=0x80000002 -> no mem req.
//     Next cycle: inst_valid=1, misalign=1, inst=0.
//     Without the macro: mem req addr 0x80000000 and misalign=0.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if
//  Bundles the core-facing fetch handshake and the instruction-memory read
//  port of the instruction fetch unit.
//  Modports:
//    slave  - the fetch unit itself (answers fetches, issues memory reads)
//    master - the environment (core + instruction memory / bus bridge)
//  Signals:
//    fetch_valid/fetch_ready/fetch_pc  fetch request from the core
//    flush                             redirect / fence.i
//    inst_valid/inst/inst_pc/misalign  returned instruction (one-cycle pulse)
//    mem_req_valid/mem_req_ready/mem_addr  64-bit aligned read request
//    mem_rsp_valid/mem_rdata               read response
interface inst_fetch_unit_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  flush;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  misalign;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  fetch_valid, fetch_pc, flush, mem_req_ready, mem_rsp_valid, mem_rdata,
        output fetch_ready, inst_valid, inst, inst_pc, misalign, mem_req_valid, mem_addr
    );

    modport master (
        output fetch_valid, fetch_pc, flush, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  fetch_ready, inst_valid, inst, inst_pc, misalign, mem_req_valid, mem_addr
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//  Instruction-side responder for the core. Accepts a fetch pc, returns the
//  32-bit instruction word, and reads memory 64 bits at a time through a
//  one-entry line buffer so both halves of a double-word cost one read.
//  Optional feature macro: IFU_MISALIGN_CHECK_EN
//    defined   - a fetch with pc[1:0]!=0 returns inst=0, misalign=1, no memory access
//    undefined - pc[1:0] is ignored and misalign is always 0
//  Ports:
//    clk  - clock, all logic on posedge
//    rst  - synchronous reset, active-high
//    bus  - inst_fetch_unit_if.slave (fetch handshake + memory read port)
//
//  state | meaning
//  IDLE  | waiting for a fetch; buffer hits answered from here
//  REQ   | read request presented, waiting for mem_req_ready
//  WAIT  | request accepted, waiting for read data
//  DROP  | flushed with a read outstanding; swallow its response
module inst_fetch_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                rst,
    inst_fetch_unit_if.slave   bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - 3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t                state, nextState;
    logic                  readyEn;
    logic                  bufValid;
    logic [TAG_WIDTH-1:0]  bufTag;
    logic [DATA_WIDTH-1:0] bufData;
    logic [ADDR_WIDTH-1:0] pcReg;
    logic                  dropPend;
    logic                  memReqValid;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  instValid;
    logic [INST_WIDTH-1:0] instReg;
    logic [ADDR_WIDTH-1:0] instPcReg;
    logic                  misalignReg;

    logic                  fetchReady;
    logic                  accept;
    logic                  handshake;
    logic                  hit;
    logic                  isMisaligned;
    logic [ADDR_WIDTH-1:0] pcEff;

`ifdef IFU_MISALIGN_CHECK_EN
    assign pcEff        = bus.fetch_pc;
    assign isMisaligned = |bus.fetch_pc[1:0];
`else
    assign pcEff        = {bus.fetch_pc[ADDR_WIDTH-1:2], 2'b00};
    assign isMisaligned = 1'b0;
`endif

    // readyEn keeps fetch_ready low until the first cycle after reset releases
    assign fetchReady = (state == IDLE) & readyEn & ~bus.flush & ~instValid;
    assign accept     = bus.fetch_valid & fetchReady;
    assign handshake  = memReqValid & bus.mem_req_ready;
    assign hit        = bufValid && (bufTag == pcEff[ADDR_WIDTH-1:3]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept && !isMisaligned && !hit) nextState = REQ;
            // a flush seen while requesting cannot retract valid; drop the data later
            REQ:  if (handshake) nextState = (dropPend || bus.flush) ? DROP : WAIT;
            WAIT: begin
                if (bus.mem_rsp_valid) nextState = IDLE;
                else if (bus.flush)    nextState = DROP;
            end
            DROP: if (bus.mem_rsp_valid) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            readyEn     <= 1'b0;
            bufValid    <= 1'b0;
            bufTag      <= '0;
            bufData     <= '0;
            pcReg       <= '0;
            dropPend    <= 1'b0;
            memReqValid <= 1'b0;
            memAddr     <= '0;
            instValid   <= 1'b0;
            instReg     <= '0;
            instPcReg   <= '0;
            misalignReg <= 1'b0;
        end else begin
            readyEn   <= 1'b1;
            instValid <= 1'b0;
            if (bus.flush) bufValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (isMisaligned) begin
                            instValid   <= 1'b1;
                            instReg     <= '0;
                            instPcReg   <= pcEff;
                            misalignReg <= 1'b1;
                        end else if (hit) begin
                            instValid   <= 1'b1;
                            instReg     <= pcEff[2] ? bufData[63:32] : bufData[31:0];
                            instPcReg   <= pcEff;
                            misalignReg <= 1'b0;
                        end else begin
                            pcReg       <= pcEff;
                            memReqValid <= 1'b1;
                            memAddr     <= {pcEff[ADDR_WIDTH-1:3], 3'b000};
                            dropPend    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (bus.flush) dropPend <= 1'b1;
                    if (handshake) memReqValid <= 1'b0;
                end
                WAIT: begin
                    // a response coinciding with flush is discarded
                    if (bus.mem_rsp_valid && !bus.flush) begin
                        bufValid    <= 1'b1;
                        bufTag      <= pcReg[ADDR_WIDTH-1:3];
                        bufData     <= bus.mem_rdata;
                        instValid   <= 1'b1;
                        instReg     <= pcReg[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
                        instPcReg   <= pcReg;
                        misalignReg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fetch_ready   = fetchReady;
    assign bus.inst_valid    = instValid;
    assign bus.inst          = instReg;
    assign bus.inst_pc       = instPcReg;
    assign bus.misalign      = misalignReg;
    assign bus.mem_req_valid = memReqValid;
    assign bus.mem_addr      = memAddr;
endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   reqCount = 0;
    int   startCount;

    inst_fetch_unit_if ifc();

    inst_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.mem_req_valid && ifc.mem_req_ready) reqCount <= reqCount + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doFetch(input logic [63:0] pc);
        ifc.fetch_valid = 1'b1;
        ifc.fetch_pc    = pc;
        step();
        ifc.fetch_valid = 1'b0;
    endtask

    task automatic respond(input logic [63:0] data);
        ifc.mem_rsp_valid = 1'b1;
        ifc.mem_rdata     = data;
        step();
        ifc.mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (ifc.fetch_ready !== 1'b0) $display("FAIL reset_fetch_ready got %0b want 0", ifc.fetch_ready); else passed++;
        total++; if (ifc.inst_valid !== 1'b0 || ifc.inst !== 32'h0 || ifc.inst_pc !== 64'h0 || ifc.misalign !== 1'b0)
            $display("FAIL reset_inst got v=%0b i=%0h pc=%0h m=%0b want all 0", ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.misalign); else passed++;
        total++; if (ifc.mem_req_valid !== 1'b0 || ifc.mem_addr !== 64'h0)
            $display("FAIL reset_mem got v=%0b a=%0h want 0/0", ifc.mem_req_valid, ifc.mem_addr); else passed++;
        rst = 1'b0;
        total++; if (ifc.fetch_ready !== 1'b0) $display("FAIL ready_same_cycle got %0b want 0", ifc.fetch_ready); else passed++;
        step();
        total++; if (ifc.fetch_ready !== 1'b1) $display("FAIL ready_after_reset got %0b want 1", ifc.fetch_ready); else passed++;
    endtask

    task automatic test_miss();
        ifc.mem_req_ready = 1'b1;
        doFetch(64'h8000_0000);
        total++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== 64'h8000_0000)
            $display("FAIL miss_req got v=%0b a=%0h want 1/80000000", ifc.mem_req_valid, ifc.mem_addr); else passed++;
        step();
        step();
        respond(64'h00000013_00100093);
        total++; if (ifc.inst_valid !== 1'b1 || ifc.inst !== 32'h00100093 || ifc.inst_pc !== 64'h8000_0000)
            $display("FAIL miss_inst got v=%0b i=%0h pc=%0h want 1/00100093/80000000", ifc.inst_valid, ifc.inst, ifc.inst_pc); else passed++;
        total++; if (reqCount !== 1) $display("FAIL miss_req_count got %0d want 1", reqCount); else passed++;
        step();
        total++; if (ifc.inst_valid !== 1'b0 || ifc.inst !== 32'h00100093)
            $display("FAIL pulse_hold got v=%0b i=%0h want 0/00100093", ifc.inst_valid, ifc.inst); else passed++;
    endtask

    task automatic test_hit();
        startCount = reqCount;
        doFetch(64'h8000_0004);
        total++; if (ifc.mem_req_valid !== 1'b0) $display("FAIL hit_no_req got %0b want 0", ifc.mem_req_valid); else passed++;
        total++; if (ifc.inst_valid !== 1'b1 || ifc.inst !== 32'h00000013 || ifc.inst_pc !== 64'h8000_0004)
            $display("FAIL hit_inst got v=%0b i=%0h pc=%0h want 1/00000013/80000004", ifc.inst_valid, ifc.inst, ifc.inst_pc); else passed++;
        step();
        total++; if (reqCount !== startCount) $display("FAIL hit_req_count got %0d want %0d", reqCount, startCount); else passed++;
    endtask

    task automatic test_req_stall();
        int stableBad = 0;
        ifc.mem_req_ready = 1'b0;
        startCount = reqCount;
        doFetch(64'h8000_0008);
        for (int i = 0; i < 5; i++) begin
            if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== 64'h8000_0008) stableBad++;
            step();
        end
        total++; if (stableBad !== 0) $display("FAIL stall_stable got %0d unstable cycles want 0", stableBad); else passed++;
        total++; if (reqCount !== startCount) $display("FAIL stall_no_hs got %0d want %0d", reqCount, startCount); else passed++;
        ifc.mem_req_ready = 1'b1;
        step();
        ifc.mem_req_ready = 1'b0;
        total++; if (reqCount !== startCount + 1 || ifc.mem_req_valid !== 1'b0)
            $display("FAIL stall_hs got cnt=%0d v=%0b want %0d/0", reqCount, ifc.mem_req_valid, startCount + 1); else passed++;
        respond(64'h11111111_22222222);
        total++; if (ifc.inst_valid !== 1'b1 || ifc.inst !== 32'h22222222)
            $display("FAIL stall_inst got v=%0b i=%0h want 1/22222222", ifc.inst_valid, ifc.inst); else passed++;
        step();
    endtask

    task automatic test_flush_wait();
        int pulses = 0;
        ifc.mem_req_ready = 1'b1;
        doFetch(64'h8000_0010);
        step();
        ifc.flush = 1'b1;
        step();
        ifc.flush = 1'b0;
        ifc.mem_rsp_valid = 1'b1;
        ifc.mem_rdata     = 64'hDEADBEEF_CAFEF00D;
        step();
        ifc.mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ifc.inst_valid !== 1'b0) pulses++;
            step();
        end
        total++; if (pulses !== 0) $display("FAIL flush_no_inst got %0d pulses want 0", pulses); else passed++;
        total++; if (ifc.fetch_ready !== 1'b1) $display("FAIL flush_back_idle got %0b want 1", ifc.fetch_ready); else passed++;
        startCount = reqCount;
        doFetch(64'h8000_0010);
        total++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== 64'h8000_0010)
            $display("FAIL refetch_req got v=%0b a=%0h want 1/80000010", ifc.mem_req_valid, ifc.mem_addr); else passed++;
        step();
        // same-cycle flush + response in WAIT: data discarded
        ifc.flush = 1'b1;
        respond(64'h55555555_66666666);
        ifc.flush = 1'b0;
        total++; if (ifc.inst_valid !== 1'b0) $display("FAIL flush_rsp_same got %0b want 0", ifc.inst_valid); else passed++;
        doFetch(64'h8000_0014);
        total++; if (ifc.mem_req_valid !== 1'b1) $display("FAIL buffer_invalid got %0b want 1", ifc.mem_req_valid); else passed++;
        step();
        respond(64'h33333333_44444444);
        total++; if (ifc.inst_valid !== 1'b1 || ifc.inst !== 32'h33333333 || ifc.inst_pc !== 64'h8000_0014)
            $display("FAIL refetch_inst got v=%0b i=%0h pc=%0h want 1/33333333/80000014", ifc.inst_valid, ifc.inst, ifc.inst_pc); else passed++;
        step();
        total++; if (reqCount !== startCount + 2) $display("FAIL refetch_count got %0d want %0d", reqCount, startCount + 2); else passed++;
    endtask

    task automatic test_flush_idle_reset();
        startCount = reqCount;
        ifc.flush = 1'b1;
        ifc.fetch_valid = 1'b1;
        ifc.fetch_pc = 64'h8000_0020;
        #1;
        total++; if (ifc.fetch_ready !== 1'b0) $display("FAIL flush_ready got %0b want 0", ifc.fetch_ready); else passed++;
        step();
        ifc.flush = 1'b0;
        ifc.fetch_valid = 1'b0;
        total++; if (ifc.mem_req_valid !== 1'b0 || ifc.inst_valid !== 1'b0)
            $display("FAIL flush_fetch got req=%0b iv=%0b want 0/0", ifc.mem_req_valid, ifc.inst_valid); else passed++;
        doFetch(64'h8000_0020);
        step();
        rst = 1'b1;
        step();
        total++; if (ifc.fetch_ready !== 1'b0 || ifc.mem_req_valid !== 1'b0 || ifc.mem_addr !== 64'h0 ||
                     ifc.inst !== 32'h0 || ifc.inst_pc !== 64'h0 || ifc.inst_valid !== 1'b0)
            $display("FAIL reset_wait got rdy=%0b req=%0b a=%0h i=%0h pc=%0h want all 0",
                     ifc.fetch_ready, ifc.mem_req_valid, ifc.mem_addr, ifc.inst, ifc.inst_pc); else passed++;
        rst = 1'b0;
        step();
        total++; if (ifc.fetch_ready !== 1'b1) $display("FAIL ready_after_rst2 got %0b want 1", ifc.fetch_ready); else passed++;
    endtask

    task automatic test_misalign();
        startCount = reqCount;
        doFetch(64'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
        total++; if (ifc.mem_req_valid !== 1'b0) $display("FAIL mis_no_req got %0b want 0", ifc.mem_req_valid); else passed++;
        total++; if (ifc.inst_valid !== 1'b1 || ifc.misalign !== 1'b1 || ifc.inst !== 32'h0)
            $display("FAIL mis_inst got v=%0b m=%0b i=%0h want 1/1/0", ifc.inst_valid, ifc.misalign, ifc.inst); else passed++;
        step();
        total++; if (reqCount !== startCount) $display("FAIL mis_count got %0d want %0d", reqCount, startCount); else passed++;
`else
        total++; if (ifc.mem_req_valid !== 1'b1 || ifc.mem_addr !== 64'h8000_0000)
            $display("FAIL mis_req got v=%0b a=%0h want 1/80000000", ifc.mem_req_valid, ifc.mem_addr); else passed++;
        step();
        respond(64'hAAAAAAAA_BBBBBBBB);
        total++; if (ifc.inst_valid !== 1'b1 || ifc.misalign !== 1'b0 || ifc.inst !== 32'hBBBBBBBB)
            $display("FAIL mis_inst got v=%0b m=%0b i=%0h want 1/0/bbbbbbbb", ifc.inst_valid, ifc.misalign, ifc.inst); else passed++;
`endif
        step();
    endtask

    initial begin
        ifc.fetch_valid   = 1'b0;
        ifc.fetch_pc      = '0;
        ifc.flush         = 1'b0;
        ifc.mem_req_ready = 1'b0;
        ifc.mem_rsp_valid = 1'b0;
        ifc.mem_rdata     = '0;
        test_reset();
        test_miss();
        test_hit();
        test_req_stall();
        test_flush_wait();
        test_flush_idle_reset();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
